// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator slice.
// Product width and FSM state encodings.
package product_accumulator_pkg;

    // Width of the multiplier product; fixed by the 2x3 multiplier.
    localparam int PROD_W = 5;

    // Frame FSM; the unused code 2'd3 recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier, the accumulator
// and the readout logic.
interface product_accumulator_if
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W = 12
) ();

    logic              start;
    logic              prod_valid;
    logic              prod_ready;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_out;
    logic              acc_valid;
    logic              acc_ready;
    logic              busy;
    logic              overflow;

    modport master (
        output start, prod_valid, prod, acc_ready,
        input  prod_ready, acc_out, acc_valid, busy, overflow
    );

    modport slave (
        input  start, prod_valid, prod, acc_ready,
        output prod_ready, acc_out, acc_valid, busy, overflow
    );

endinterface

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned adder with one guard bit.
// Carry out tells the caller that the sum no longer fits.
module sat_adder #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] a,
    input  logic [IN_W-1:0]  b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] wide;

    // Zero-extend the product and add with an extra carry bit.
    assign wide  = {1'b0, a} + {{(ACC_W + 1 - IN_W){1'b0}}, b};
    assign sum   = wide[ACC_W-1:0];
    assign carry = wide[ACC_W];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a frame of N_TERMS products with saturation and
// hands the sum to the readout logic over valid/ready.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    product_accumulator_if.slave io
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [ACC_W-1:0] sum;
    logic             carry;

    sat_adder #(
        .IN_W  (PROD_W),
        .ACC_W (ACC_W)
    ) u_add (
        .a     (acc),
        .b     (io.prod),
        .sum   (sum),
        .carry (carry)
    );

    // Frame FSM with the running sum, term counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io.start) begin
                        state <= ST_ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (io.prod_valid) begin
                        acc <= (carry || ovf) ? '1 : sum;
                        ovf <= ovf | carry;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (io.acc_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the registered state.
    assign io.prod_ready = (state == ST_ACCUM);
    assign io.acc_valid  = (state == ST_HOLD);
    assign io.busy       = (state == ST_ACCUM) || (state == ST_HOLD);
    assign io.acc_out    = acc;
    assign io.overflow   = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: default instance (12-bit, 8 terms)
// and a small saturating instance (6-bit, 4 terms).
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    product_accumulator_if #(.ACC_W(12)) ia ();
    product_accumulator_if #(.ACC_W(6))  ib ();

    product_accumulator #(
        .ACC_W   (12),
        .N_TERMS (8),
        .CNT_W   (4)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ia.slave)
    );

    product_accumulator #(
        .ACC_W   (6),
        .N_TERMS (4),
        .CNT_W   (4)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ib.slave)
    );

    bit       st [2];
    bit       pv [2];
    bit [4:0] pd [2];
    bit       ar [2];

    assign ia.start      = st[0];
    assign ia.prod_valid = pv[0];
    assign ia.prod       = pd[0];
    assign ia.acc_ready  = ar[0];
    assign ib.start      = st[1];
    assign ib.prod_valid = pv[1];
    assign ib.prod       = pd[1];
    assign ib.acc_ready  = ar[1];

    int acc_o [2];
    int av_o  [2];
    int pr_o  [2];
    int bz_o  [2];
    int ov_o  [2];

    assign acc_o[0] = int'(ia.acc_out);
    assign acc_o[1] = int'(ib.acc_out);
    assign av_o[0]  = int'(ia.acc_valid);
    assign av_o[1]  = int'(ib.acc_valid);
    assign pr_o[0]  = int'(ia.prod_ready);
    assign pr_o[1]  = int'(ib.prod_ready);
    assign bz_o[0]  = int'(ia.busy);
    assign bz_o[1]  = int'(ib.busy);
    assign ov_o[0]  = int'(ia.overflow);
    assign ov_o[1]  = int'(ib.overflow);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: exact frame sum and term count; outputs are derived by
    // clamping the exact sum to the accumulator range.
    // mode 0 = waiting for start, 1 = taking terms, 2 = result offered.
    localparam int MAXV [2] = '{4095, 63};
    localparam int NT   [2] = '{8, 4};

    int m_mode [2];
    int m_sum  [2];
    int m_n    [2];
    bit armed = 1'b0;

    always @(posedge clk) begin
        armed <= 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_mode[k] <= 0;
                m_sum[k]  <= 0;
                m_n[k]    <= 0;
            end else if (m_mode[k] == 0) begin
                if (st[k]) begin
                    m_mode[k] <= 1;
                    m_sum[k]  <= 0;
                    m_n[k]    <= 0;
                end
            end else if (m_mode[k] == 1) begin
                if (pv[k]) begin
                    m_sum[k] <= m_sum[k] + int'(pd[k]);
                    m_n[k]   <= m_n[k] + 1;
                    if (m_n[k] + 1 == NT[k]) m_mode[k] <= 2;
                end
            end else begin
                if (ar[k]) m_mode[k] <= 0;
            end
        end
    end

    function automatic int exp_acc(input int k);
        return (m_sum[k] > MAXV[k]) ? MAXV[k] : m_sum[k];
    endfunction

    // Every cycle, both instances against the model.
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d_acc", k), acc_o[k], exp_acc(k));
                chk($sformatf("m%0d_ovf", k), ov_o[k],
                    int'(m_sum[k] > MAXV[k]));
                chk($sformatf("m%0d_av", k), av_o[k], int'(m_mode[k] == 2));
                chk($sformatf("m%0d_pr", k), pr_o[k], int'(m_mode[k] == 1));
                chk($sformatf("m%0d_busy", k), bz_o[k], int'(m_mode[k] != 0));
            end
        end
    end

    task automatic start_frame(input int k);
        st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
    endtask

    // Offer one product and hold it until accepted (bounded).
    task automatic send(input int k, input int p);
        bit took;
        pv[k] = 1'b1;
        pd[k] = 5'(p);
        for (int i = 0; i < 50; i++) begin
            took = (pr_o[k] != 0);
            @(negedge clk);
            if (took) begin
                pv[k] = 1'b0;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        pv[k] = 1'b0;
    endtask

    task automatic release_result(input int k);
        ar[k] = 1'b1;
        @(negedge clk);
        ar[k] = 1'b0;
    endtask

    initial begin
        int vals [8];

        // 1: reset held with start high
        rst_n = 1'b0;
        st[0] = 1'b1;
        st[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_acc", acc_o[0], 0);
        chk("rst_av", av_o[0], 0);
        chk("rst_pr", pr_o[0], 0);
        chk("rst_busy", bz_o[0], 0);
        chk("rst_ovf", ov_o[0], 0);
        rst_n = 1'b1;
        st[0] = 1'b0;
        st[1] = 1'b0;
        @(negedge clk);
        chk("idle_busy", bz_o[0], 0);

        // 2: nominal frame
        start_frame(0);
        vals = '{1, 2, 3, 4, 5, 6, 7, 21};
        foreach (vals[i]) send(0, vals[i]);
        chk("nom_av_latency", av_o[0], 1);
        chk("nom_sum", acc_o[0], 49);
        chk("nom_ovf", ov_o[0], 0);
        release_result(0);
        chk("nom_av_drop", av_o[0], 0);

        // 3: products offered while idle are ignored, then gapped frame
        pv[0] = 1'b1;
        pd[0] = 5'd9;
        @(negedge clk);
        @(negedge clk);
        pv[0] = 1'b0;
        chk("idle_pr", pr_o[0], 0);
        start_frame(0);
        vals = '{3, 0, 10, 5, 7, 2, 9, 4};
        foreach (vals[i]) begin
            @(negedge clk);
            send(0, vals[i]);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum", acc_o[0], 40);
            chk("bp_pr", pr_o[0], 0);
            @(negedge clk);
        end
        release_result(0);
        chk("bp_keep_sum", acc_o[0], 40);

        // 4: saturation on the small instance
        start_frame(1);
        send(1, 21);
        send(1, 21);
        send(1, 21);
        chk("sat_at3", acc_o[1], 63);
        chk("sat_ovf3", ov_o[1], 0);
        send(1, 21);
        chk("sat_at4", acc_o[1], 63);
        chk("sat_ovf4", ov_o[1], 1);
        release_result(1);
        chk("sat_ovf_idle", ov_o[1], 1);
        start_frame(1);
        chk("sat_ovf_clr", ov_o[1], 0);
        chk("sat_acc_clr", acc_o[1], 0);
        repeat (4) send(1, 0);
        chk("zero_terms_av", av_o[1], 1);
        release_result(1);

        // 5: start ignored mid-frame and in HOLD
        start_frame(0);
        send(0, 5);
        st[0] = 1'b1;
        send(0, 6);
        st[0] = 1'b0;
        vals = '{7, 1, 1, 1, 1, 1, 0, 0};
        for (int i = 0; i < 6; i++) send(0, vals[i]);
        chk("ign_sum", acc_o[0], 23);
        st[0] = 1'b1;
        ar[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        ar[0] = 1'b0;
        @(negedge clk);
        chk("hold_start_busy", bz_o[0], 0);
        chk("hold_start_pr", pr_o[0], 0);

        // 5b: abort after three accepts
        start_frame(0);
        send(0, 2);
        send(0, 2);
        send(0, 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("abort_av", av_o[0], 0);
            @(negedge clk);
        end
        chk("abort_busy", bz_o[0], 0);

        // 6: largest frame on the default instance
        start_frame(0);
        repeat (8) send(0, 21);
        chk("max_sum", acc_o[0], 168);
        chk("max_ovf", ov_o[0], 0);
        release_result(0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
